// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The checksum stage is only reachable when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_pkg;

   localparam int IMEM_DEPTH      = 256;
   localparam int INSTR_W         = 32;
   localparam int BYTE_ADDR_SHIFT = 2;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      LOAD,
      WFIN,
      CHK,
      DONE,
      ERROR
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if
   import imem_pkg::*;
   ;

   logic [7:0]         in_data;
   logic               in_valid;
   logic               in_ready;
   logic               we;
   logic [INSTR_W-1:0] waddr;
   logic [INSTR_W-1:0] wdata;

   modport master (
      input  in_data, in_valid,
      output in_ready, we, waddr, wdata
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, we, waddr, wdata
   );

endinterface

// File: rtl/imem_word_assembler.sv
// Collects four stream bytes MSB-first into one instruction word.
// word_done/word are valid in the same cycle as the fourth accepted byte.
module imem_word_assembler
   import imem_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               take,
   input  logic [7:0]         byte_in,
   output logic               word_done,
   output logic [INSTR_W-1:0] word
);

   logic [1:0]  cnt;
   logic [23:0] sr;

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt <= '0;
         sr  <= '0;
      end else if (take) begin
         cnt <= cnt + 2'd1;
         sr  <= {sr[15:0], byte_in};
      end
   end

   // The fourth byte bypasses the shift register so the full word is
   // available without waiting an extra cycle.
   assign word_done = take && (cnt == 2'd3);
   assign word      = {sr, byte_in};

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: header N, then N big-endian words written to imem; core
// held in reset until done. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader
   import imem_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH,
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   imem_loader_if.master    bus,
   output logic [CNT_W-1:0] words_loaded,
   output logic             done,
   output logic             error,
   output logic             cpu_rst_n
);

   localparam int IDX_W = $clog2(DEPTH);

   state_t      state;
   logic [15:0] n_words;
   logic [15:0] hdr_n;
   logic        accept;
   logic        restart;
   logic        last_word;
   logic        word_done;
   logic [INSTR_W-1:0] word;

   assign accept    = bus.in_valid && bus.in_ready;
   assign restart   = start && (state == IDLE || state == DONE || state == ERROR);
   assign hdr_n     = {n_words[15:8], bus.in_data};
   assign last_word = (words_loaded + CNT_W'(1)) == CNT_W'(n_words);

   imem_word_assembler u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (restart),
      .take      (accept && state == LOAD),
      .byte_in   (bus.in_data),
      .word_done (word_done),
      .word      (word)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk) begin
      if (!rst_n || restart)
         csum <= '0;
      else if (accept && state == LOAD)
         csum <= csum ^ bus.in_data;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         n_words      <= '0;
         bus.in_ready <= 1'b0;
         bus.we       <= 1'b0;
         bus.waddr    <= '0;
         bus.wdata    <= '0;
         words_loaded <= '0;
         done         <= 1'b0;
         error        <= 1'b0;
         cpu_rst_n    <= 1'b0;
      end else begin
         bus.we <= 1'b0;

         if (word_done) begin
            bus.we       <= 1'b1;
            bus.waddr    <= INSTR_W'(words_loaded[IDX_W-1:0]) << BYTE_ADDR_SHIFT;
            bus.wdata    <= word;
            words_loaded <= words_loaded + CNT_W'(1);
         end

         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state        <= HDR0;
                  bus.in_ready <= 1'b1;
                  words_loaded <= '0;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  cpu_rst_n    <= 1'b0;
               end
            end
            HDR0: begin
               if (accept) begin
                  n_words[15:8] <= bus.in_data;
                  state         <= HDR1;
               end
            end
            HDR1: begin
               if (accept) begin
                  n_words[7:0] <= bus.in_data;
                  if (hdr_n == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state <= CHK;
`else
                     state        <= DONE;
                     bus.in_ready <= 1'b0;
                     done         <= 1'b1;
                     cpu_rst_n    <= 1'b1;
`endif
                  end else if (32'(hdr_n) > 32'(DEPTH)) begin
                     // Oversized image is rejected before any write happens.
                     state        <= ERROR;
                     bus.in_ready <= 1'b0;
                     error        <= 1'b1;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (word_done && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state <= CHK;
`else
                  state        <= WFIN;
                  bus.in_ready <= 1'b0;
`endif
               end
            end
            WFIN: begin
               state     <= DONE;
               done      <= 1'b1;
               cpu_rst_n <= 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
               if (accept) begin
                  bus.in_ready <= 1'b0;
                  if (csum == bus.in_data) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     cpu_rst_n <= 1'b1;
                  end else begin
                     state <= ERROR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state        <= IDLE;
               bus.in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames built from a word list, expected
// writes and final status derived from the frame rules, randomized stalls/start.
module tb_imem_loader;

   localparam int DEPTH = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] words_loaded;
   logic        done;
   logic        error;
   logic        cpu_rst_n;

   imem_loader_if bus ();

   imem_loader #(.DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .bus          (bus.master),
      .words_loaded (words_loaded),
      .done         (done),
      .error        (error),
      .cpu_rst_n    (cpu_rst_n)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] wlog[$];
   logic [31:0] words_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Every write-port pulse is captured as {waddr, wdata}.
   always @(negedge clk)
      if (bus.we === 1'b1) wlog.push_back({bus.waddr, bus.wdata});

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic send_byte(input logic [7:0] b, input int gap_max, input bit noisy);
      int gaps;
      int t;
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int g = 0; g < gaps; g++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_data  = 8'($urandom);
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      start        = noisy ? 1'($urandom_range(1, 0)) : 1'b0;
      t = 0;
      while (!bus.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) check("ready_timeout", 0, 1);
      @(posedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_in_ready", bus.in_ready, 1);
      check("start_done", done, 0);
      check("start_error", error, 0);
      check("start_words", words_loaded, 0);
      check("start_cpu_rst_n", cpu_rst_n, 0);
   endtask

   // Sends a complete frame for n words from words_q and checks the outcome.
   // csum_mask is XORed into the checksum byte (nonzero = corrupted).
   task automatic run_frame(input logic [15:0] n, input logic [7:0] csum_mask,
                            input int gap_max, input bit noisy);
      logic [7:0] x;
      bit         hdr_bad;
      bit         ok;
      int         lat;
      int         n_exp;
      logic [63:0] got;
      hdr_bad = (n > 16'(DEPTH));
      ok      = !hdr_bad && (!CSUM || csum_mask == 8'h00);
      lat     = (CSUM || n == 16'd0 || hdr_bad) ? 1 : 2;
      n_exp   = hdr_bad ? 0 : int'(n);
      wlog.delete();
      pulse_start();
      send_byte(n[15:8], gap_max, noisy);
      send_byte(n[7:0], gap_max, noisy);
      x = 8'h00;
      if (!hdr_bad) begin
         for (int i = 0; i < int'(n); i++)
            for (int b = 3; b >= 0; b--) begin
               x ^= words_q[i][8*b +: 8];
               send_byte(words_q[i][8*b +: 8], gap_max, noisy);
            end
         if (CSUM) send_byte(x ^ csum_mask, gap_max, noisy);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      start        = 1'b0;
      if (lat == 2) begin
         check("done_early", done, 0);
         check("cpu_rst_early", cpu_rst_n, 0);
         @(negedge clk);
      end
      check("done", done, ok);
      check("error", error, !ok);
      check("cpu_rst_n", cpu_rst_n, ok);
      check("in_ready_end", bus.in_ready, 0);
      check("words_loaded", words_loaded, n_exp);
      check("we_count", wlog.size(), n_exp);
      for (int i = 0; i < n_exp; i++) begin
         got = (i < wlog.size()) ? wlog[i] : '1;
         check("waddr", got[63:32], i * 4);
         check("wdata", got[31:0], words_q[i]);
      end
   endtask

   task automatic fill_words(input int n);
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
   endtask

   initial begin
      logic [15:0] n;
      logic [7:0]  mask;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      repeat (2) @(negedge clk);
      check("rst_we", bus.we, 0);
      check("rst_waddr", bus.waddr, 0);
      check("rst_wdata", bus.wdata, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_words", words_loaded, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_cpu_rst_n", cpu_rst_n, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_in_ready", bus.in_ready, 0);

      words_q = '{32'h012A4020, 32'h01095820, 32'h016A6022};
      run_frame(16'd3, 8'h00, 0, 1'b0);

      words_q.delete();
      run_frame(16'd0, 8'h00, 0, 1'b0);
      run_frame(16'd257, 8'h00, 0, 1'b0);

      fill_words(2);
      run_frame(16'd2, 8'h00, 0, 1'b0);
      run_frame(16'd2, 8'h00, 3, 1'b0);

      // Reset in the middle of the second word of a two-word load.
      fill_words(2);
      wlog.delete();
      pulse_start();
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h02, 0, 1'b0);
      for (int i = 0; i < 6; i++) send_byte(words_q[i / 4][8*(3 - i % 4) +: 8], 0, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      @(negedge clk);
      check("mid_rst_we", bus.we, 0);
      check("mid_rst_waddr", bus.waddr, 0);
      check("mid_rst_wdata", bus.wdata, 0);
      check("mid_rst_in_ready", bus.in_ready, 0);
      check("mid_rst_words", words_loaded, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_error", error, 0);
      check("mid_rst_cpu_rst_n", cpu_rst_n, 0);
      check("mid_rst_writes", wlog.size(), 1);
      rst_n = 1'b1;
      fill_words(2);
      run_frame(16'd2, 8'h00, 0, 1'b0);

      for (int k = 0; k < 12; k++) begin
         n = 16'($urandom_range(8, 1));
         fill_words(int'(n));
         mask = (CSUM && $urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
         run_frame(n, mask, 3, 1'b1);
      end

      fill_words(DEPTH);
      run_frame(16'(DEPTH), 8'h00, 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      words_q = '{32'h012A4020};
      run_frame(16'd1, 8'h00, 0, 1'b0);
      run_frame(16'd1, 8'h4B, 0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
